// File: rtl/sap_controller.sv
// SAP-U control sequencer: six-state T1..T6 ring plus HALT, decoding the
// control word from the current T-state and the instruction opcode.
module sap_controller #(
  parameter bit SHORT_CYCLE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       step_mode,
  input  logic       step,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       reg_a_load,
  output logic       reg_a_enable,
  output logic       reg_b_load,
  output logic       alu_enable,
  output logic       alu_subtract,
  output logic       out_load,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef struct packed {
    logic pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
    logic reg_a_load, reg_a_enable, reg_b_load;
    logic alu_enable, alu_subtract, out_load;
  } ctl_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_e state_q, state_d;
  ctl_t   ctl;
  logic   advance;
  logic   is_lda, is_arith, is_out, is_hlt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_T1;
    else       state_q <= state_d;
  end

  assign advance  = !step_mode || step;
  assign is_lda   = (opcode == OP_LDA);
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_out   = (opcode == OP_OUT);
  assign is_hlt   = (opcode == OP_HLT);

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    t_state = 6'b000000;
    halted  = 1'b0;
    unique case (state_q)
      S_T1: begin
        t_state      = 6'b000001;
        ctl.pc_out   = 1'b1;
        ctl.mar_load = 1'b1;
        if (advance) state_d = S_T2;
      end
      S_T2: begin
        t_state    = 6'b000010;
        ctl.pc_inc = 1'b1;
        if (advance) state_d = S_T3;
      end
      S_T3: begin
        t_state     = 6'b000100;
        ctl.ram_out = 1'b1;
        ctl.ir_load = 1'b1;
        if (advance) state_d = S_T4;
      end
      S_T4: begin
        t_state = 6'b001000;
        if (is_lda || is_arith) begin
          ctl.ir_out   = 1'b1;
          ctl.mar_load = 1'b1;
        end else if (is_out) begin
          ctl.reg_a_enable = 1'b1;
          ctl.out_load     = 1'b1;
        end
        if (advance) begin
          if (is_hlt)                                 state_d = S_HALT;
          else if (SHORT_CYCLE && !is_lda && !is_arith) state_d = S_T1;
          else                                        state_d = S_T5;
        end
      end
      S_T5: begin
        t_state = 6'b010000;
        if (is_lda) begin
          ctl.ram_out    = 1'b1;
          ctl.reg_a_load = 1'b1;
        end else if (is_arith) begin
          ctl.ram_out    = 1'b1;
          ctl.reg_b_load = 1'b1;
        end
        if (advance) state_d = (SHORT_CYCLE && is_lda) ? S_T1 : S_T6;
      end
      S_T6: begin
        t_state = 6'b100000;
        if (is_arith) begin
          ctl.alu_enable   = 1'b1;
          ctl.reg_a_load   = 1'b1;
          ctl.alu_subtract = (opcode == OP_SUB);
        end
        if (advance) state_d = S_T1;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_T1;
    endcase
  end

  // Reset state is T1, whose strobes must not leak out while reset is held.
  assign pc_out       = !reset && ctl.pc_out;
  assign ram_out      = !reset && ctl.ram_out;
  assign ir_out       = !reset && ctl.ir_out;
  assign reg_a_enable = !reset && ctl.reg_a_enable;
  assign alu_enable   = !reset && ctl.alu_enable;
  assign alu_subtract = !reset && ctl.alu_subtract;

  // Loads and increments fire only on the cycle whose edge advances the state.
  assign pc_inc     = !reset && advance && ctl.pc_inc;
  assign mar_load   = !reset && advance && ctl.mar_load;
  assign ir_load    = !reset && advance && ctl.ir_load;
  assign reg_a_load = !reset && advance && ctl.reg_a_load;
  assign reg_b_load = !reset && advance && ctl.reg_b_load;
  assign out_load   = !reset && advance && ctl.out_load;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: full-cycle and short-cycle instances
// share stimulus and are checked against hand-computed control words.
module tb_sap_controller;

  localparam logic [11:0] PC_OUT   = 12'h800;
  localparam logic [11:0] PC_INC   = 12'h400;
  localparam logic [11:0] MAR      = 12'h200;
  localparam logic [11:0] RAM_OUT  = 12'h100;
  localparam logic [11:0] IR_LOAD  = 12'h080;
  localparam logic [11:0] IR_OUT   = 12'h040;
  localparam logic [11:0] A_LOAD   = 12'h020;
  localparam logic [11:0] A_EN     = 12'h010;
  localparam logic [11:0] B_LOAD   = 12'h008;
  localparam logic [11:0] ALU_EN   = 12'h004;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] OUT_LOAD = 12'h001;
  localparam logic [11:0] NONE     = 12'h000;
  localparam logic [11:0] F1 = PC_OUT | MAR;
  localparam logic [11:0] F2 = PC_INC;
  localparam logic [11:0] F3 = RAM_OUT | IR_LOAD;

  logic       clk, reset, step_mode, step;
  logic [3:0] opcode;

  logic pc_out0, pc_inc0, mar_load0, ram_out0, ir_load0, ir_out0;
  logic reg_a_load0, reg_a_enable0, reg_b_load0, alu_enable0, alu_subtract0, out_load0;
  logic [5:0] t_state0;
  logic halted0;
  logic pc_out1, pc_inc1, mar_load1, ram_out1, ir_load1, ir_out1;
  logic reg_a_load1, reg_a_enable1, reg_b_load1, alu_enable1, alu_subtract1, out_load1;
  logic [5:0] t_state1;
  logic halted1;

  sap_controller #(.SHORT_CYCLE(1'b0)) dut_full (
    .clk(clk), .reset(reset), .opcode(opcode), .step_mode(step_mode), .step(step),
    .pc_out(pc_out0), .pc_inc(pc_inc0), .mar_load(mar_load0), .ram_out(ram_out0),
    .ir_load(ir_load0), .ir_out(ir_out0), .reg_a_load(reg_a_load0),
    .reg_a_enable(reg_a_enable0), .reg_b_load(reg_b_load0), .alu_enable(alu_enable0),
    .alu_subtract(alu_subtract0), .out_load(out_load0), .t_state(t_state0), .halted(halted0)
  );

  sap_controller #(.SHORT_CYCLE(1'b1)) dut_short (
    .clk(clk), .reset(reset), .opcode(opcode), .step_mode(step_mode), .step(step),
    .pc_out(pc_out1), .pc_inc(pc_inc1), .mar_load(mar_load1), .ram_out(ram_out1),
    .ir_load(ir_load1), .ir_out(ir_out1), .reg_a_load(reg_a_load1),
    .reg_a_enable(reg_a_enable1), .reg_b_load(reg_b_load1), .alu_enable(alu_enable1),
    .alu_subtract(alu_subtract1), .out_load(out_load1), .t_state(t_state1), .halted(halted1)
  );

  logic [11:0] ctl0, ctl1;
  assign ctl0 = {pc_out0, pc_inc0, mar_load0, ram_out0, ir_load0, ir_out0,
                 reg_a_load0, reg_a_enable0, reg_b_load0, alu_enable0, alu_subtract0, out_load0};
  assign ctl1 = {pc_out1, pc_inc1, mar_load1, ram_out1, ir_load1, ir_out1,
                 reg_a_load1, reg_a_enable1, reg_b_load1, alu_enable1, alu_subtract1, out_load1};

  typedef struct {
    logic        pre_rst;
    logic [3:0]  op;
    logic        sm;
    logic        st;
    logic [5:0]  t0;
    logic [11:0] c0;
    logic [5:0]  t1;
    logic [11:0] c1;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic pr, input logic [3:0] op, input logic sm, input logic st,
                     input logic [5:0] t0, input logic [11:0] c0,
                     input logic [5:0] t1, input logic [11:0] c1);
    vec_t v;
    v.pre_rst = pr; v.op = op; v.sm = sm; v.st = st;
    v.t0 = t0; v.c0 = c0; v.t1 = t1; v.c1 = c1;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctl_full"},  {20'd0, ctl0}, 32'd0);
    check({name, " ctl_short"}, {20'd0, ctl1}, 32'd0);
    check({name, " t_full"},    {26'd0, t_state0}, 32'd0);
    check({name, " t_short"},   {26'd0, t_state1}, 32'd0);
    check({name, " halt_full"}, {31'd0, halted0}, 32'd1);
    check({name, " halt_short"},{31'd0, halted1}, 32'd1);
  endtask

  task automatic check_reset_state(input string name);
    check({name, " ctl_full"},  {20'd0, ctl0}, 32'd0);
    check({name, " ctl_short"}, {20'd0, ctl1}, 32'd0);
    check({name, " t_full"},    {26'd0, t_state0}, 32'h01);
    check({name, " t_short"},   {26'd0, t_state1}, 32'h01);
    check({name, " halt_full"}, {31'd0, halted0}, 32'd0);
    check({name, " halt_short"},{31'd0, halted1}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; opcode = 4'h0; step_mode = 1'b0; step = 1'b0;

    // ADD, full cycle on both instances
    add(1, 4'h1, 0, 0, 6'h01, F1,               6'h01, F1);
    add(0, 4'h1, 0, 0, 6'h02, F2,               6'h02, F2);
    add(0, 4'h1, 0, 0, 6'h04, F3,               6'h04, F3);
    add(0, 4'h1, 0, 0, 6'h08, IR_OUT | MAR,     6'h08, IR_OUT | MAR);
    add(0, 4'h1, 0, 0, 6'h10, RAM_OUT | B_LOAD, 6'h10, RAM_OUT | B_LOAD);
    add(0, 4'h1, 0, 0, 6'h20, ALU_EN | A_LOAD,  6'h20, ALU_EN | A_LOAD);
    // SUB, with a junk opcode during T1/T2 that must not matter
    add(0, 4'hF, 0, 0, 6'h01, F1,               6'h01, F1);
    add(0, 4'h7, 0, 0, 6'h02, F2,               6'h02, F2);
    add(0, 4'h2, 0, 0, 6'h04, F3,               6'h04, F3);
    add(0, 4'h2, 0, 0, 6'h08, IR_OUT | MAR,     6'h08, IR_OUT | MAR);
    add(0, 4'h2, 0, 0, 6'h10, RAM_OUT | B_LOAD, 6'h10, RAM_OUT | B_LOAD);
    add(0, 4'h2, 0, 0, 6'h20, ALU_EN | A_LOAD | ALU_SUB, 6'h20, ALU_EN | A_LOAD | ALU_SUB);
    add(0, 4'h2, 0, 0, 6'h01, F1,               6'h01, F1);
    // OUT: short instance returns to T1 after T4
    add(1, 4'hE, 0, 0, 6'h01, F1,               6'h01, F1);
    add(0, 4'hE, 0, 0, 6'h02, F2,               6'h02, F2);
    add(0, 4'hE, 0, 0, 6'h04, F3,               6'h04, F3);
    add(0, 4'hE, 0, 0, 6'h08, A_EN | OUT_LOAD,  6'h08, A_EN | OUT_LOAD);
    add(0, 4'hE, 0, 0, 6'h10, NONE,             6'h01, F1);
    add(0, 4'hE, 0, 0, 6'h20, NONE,             6'h02, F2);
    add(0, 4'hE, 0, 0, 6'h01, F1,               6'h04, F3);
    // LDA: short instance returns to T1 after T5
    add(1, 4'h0, 0, 0, 6'h01, F1,               6'h01, F1);
    add(0, 4'h0, 0, 0, 6'h02, F2,               6'h02, F2);
    add(0, 4'h0, 0, 0, 6'h04, F3,               6'h04, F3);
    add(0, 4'h0, 0, 0, 6'h08, IR_OUT | MAR,     6'h08, IR_OUT | MAR);
    add(0, 4'h0, 0, 0, 6'h10, RAM_OUT | A_LOAD, 6'h10, RAM_OUT | A_LOAD);
    add(0, 4'h0, 0, 0, 6'h20, NONE,             6'h01, F1);
    add(0, 4'h0, 0, 0, 6'h01, F1,               6'h02, F2);
    // Unknown opcode 0111 acts as NOP
    add(1, 4'h7, 0, 0, 6'h01, F1,               6'h01, F1);
    add(0, 4'h7, 0, 0, 6'h02, F2,               6'h02, F2);
    add(0, 4'h7, 0, 0, 6'h04, F3,               6'h04, F3);
    add(0, 4'h7, 0, 0, 6'h08, NONE,             6'h08, NONE);
    add(0, 4'h7, 0, 0, 6'h10, NONE,             6'h01, F1);
    // Single-step: hold in T2, then step once
    add(1, 4'h0, 0, 0, 6'h01, F1,               6'h01, F1);
    for (int k = 0; k < 5; k++)
      add(0, 4'h0, 1, 0, 6'h02, NONE,           6'h02, NONE);
    add(0, 4'h0, 1, 1, 6'h02, F2,               6'h02, F2);
    add(0, 4'h0, 1, 0, 6'h04, RAM_OUT,          6'h04, RAM_OUT);
    add(0, 4'h0, 1, 1, 6'h04, F3,               6'h04, F3);
    add(0, 4'h0, 1, 1, 6'h08, IR_OUT | MAR,     6'h08, IR_OUT | MAR);
    add(0, 4'h0, 1, 1, 6'h10, RAM_OUT | A_LOAD, 6'h10, RAM_OUT | A_LOAD);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].pre_rst) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      opcode = vecs[i].op; step_mode = vecs[i].sm; step = vecs[i].st;
      #1;
      check($sformatf("vec%0d t_full", i),    {26'd0, t_state0}, {26'd0, vecs[i].t0});
      check($sformatf("vec%0d ctl_full", i),  {20'd0, ctl0},     {20'd0, vecs[i].c0});
      check($sformatf("vec%0d halt_full", i), {31'd0, halted0},  32'd0);
      check($sformatf("vec%0d t_short", i),   {26'd0, t_state1}, {26'd0, vecs[i].t1});
      check($sformatf("vec%0d ctl_short", i), {20'd0, ctl1},     {20'd0, vecs[i].c1});
      check($sformatf("vec%0d halt_short", i),{31'd0, halted1},  32'd0);
    end

    // Reset held high: T1 strobes must be suppressed
    @(negedge clk);
    step_mode = 1'b0; step = 1'b0; opcode = 4'hF;
    reset = 1'b1;
    #1;
    check_reset_state("reset_held");
    reset = 1'b0;

    // HLT: reaches HALT on the edge ending T4 and stays there
    repeat (3) @(negedge clk);
    #1;
    check("hlt_t4 t_full",    {26'd0, t_state0}, 32'h08);
    check("hlt_t4 ctl_full",  {20'd0, ctl0},     32'd0);
    check("hlt_t4 t_short",   {26'd0, t_state1}, 32'h08);
    check("hlt_t4 ctl_short", {20'd0, ctl1},     32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) opcode = 4'h1;
      #1;
      check_all_zero($sformatf("halt%0d", k));
    end
    reset = 1'b1;
    #1;
    check_reset_state("halt_reset");
    reset = 1'b0;

    // Async reset in the middle of LDA T5
    opcode = 4'h0;
    repeat (4) @(negedge clk);
    #1;
    check("lda_t5 ctl_full",  {20'd0, ctl0}, {20'd0, RAM_OUT | A_LOAD});
    check("lda_t5 ctl_short", {20'd0, ctl1}, {20'd0, RAM_OUT | A_LOAD});
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset t_full",   {26'd0, t_state0}, 32'h01);
    check("post_reset ctl_full", {20'd0, ctl0},     {20'd0, F1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
# sap_controller

Control sequencer for the SAP-U datapath. A six-state ring counter (T1..T6) steps through fetch and execute micro-operations. Each state's control word is decoded from the current T-state and the 4-bit opcode held in the instruction register. The controller drives the load, enable and increment strobes of the PC, MAR, RAM, IR, register A, register B, ALU and output register. It sits beside the datapath at top level and owns its sequencing, including halt and single-step.

## Interface
- SHORT_CYCLE, 0, 1: return to T1 immediately after an instruction's last active T-state; 0: every instruction takes 6 states.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces T1, clears halt.
- opcode  in  4  IR[7:4]; sampled only in T4..T6.
- step_mode  in  1  1 = single-step; state advances only when step=1.
- step  in  1  advance qualifier in step mode; ignored when step_mode=0.
- pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out  out  1 each  PC/MAR/RAM/IR controls.
- reg_a_load, reg_a_enable, reg_b_load  out  1 each  register controls.
- alu_enable, alu_subtract  out  1 each  ALU controls.
- out_load  out  1  output register load.
- t_state  out  6  one-hot current T-state; bit0 = T1.
- halted  out  1  high while in HALT.

## Operation
- States: T1..T6 (one-hot ring) and HALT.
- Transitions on rising edge when advance = !step_mode | step:
  - Tn -> Tn+1.
  - T6 -> T1.
  - T4 with opcode HLT -> HALT.
  - HALT holds until reset.
- Fetch, all opcodes:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute:
  - LDA 0000: T4 ir_out+mar_load; T5 ram_out+reg_a_load; T6 none.
  - ADD 0001: T4 ir_out+mar_load; T5 ram_out+reg_b_load; T6 alu_enable+reg_a_load.
  - SUB 0010: same as ADD, plus alu_subtract in T6.
  - OUT 1110: T4 reg_a_enable+out_load; T5, T6 none.
  - HLT 1111: T4 no strobes; next state HALT.
  - Any other opcode: NOP, no strobes in T4..T6.
- SHORT_CYCLE=1 early return to T1:
  - LDA: after T5.
  - OUT and NOP: after T4.
  - ADD/SUB: full 6 states.
- Strobe classes:
  - Load/increment strobes (pc_inc, mar_load, ir_load, reg_a_load, reg_b_load, out_load) are gated by advance. In step mode they pulse only on the cycle whose edge advances the state, so no register loads or increments twice.
  - Bus-drive/mode outputs (pc_out, ram_out, ir_out, reg_a_enable, alu_enable, alu_subtract) follow the decoded state regardless of advance.
- Bus exclusivity: at most one of pc_out, ram_out, ir_out, reg_a_enable, alu_enable is high in any state.
- HALT: every control output 0; t_state = 000000; halted = 1.

## Timing
- Control outputs are combinational from state, opcode, step_mode and step. They are valid for the whole T-state and consumed by the datapath at the rising edge that ends the state.
- While reset is high:
  - state = T1, t_state = 000001, halted = 0.
  - All control outputs forced to 0.
- After reset deasserts, the first T1 drives pc_out and mar_load.
- Reset asserted mid-instruction or in HALT takes effect immediately (async). No partial strobe survives.
- Latency, step_mode=0:
  - Full cycle: 6 clocks per instruction.
  - SHORT_CYCLE=1: LDA 5, OUT/NOP 4, HLT reaches HALT on the edge ending T4.
- step_mode changes take effect the same cycle. If step is held high in step mode, the controller behaves as free-run.
- opcode changes during T1..T3 must not affect outputs. Decode ignores opcode outside T4..T6.

## Test plan
- Reset then free-run, opcode=0001 (ADD): t_state sequences 01,02,04,08,10,20,01. Check strobes per state: T1 pc_out+mar_load; T5 ram_out+reg_b_load; T6 alu_enable+reg_a_load with alu_subtract=0.
- SUB 0010, then OUT 1110, SHORT_CYCLE=0 vs 1: SUB T6 has alu_subtract=1. OUT asserts reg_a_enable+out_load in T4. OUT returns to T1 after T4 when SHORT_CYCLE=1, after T6 when SHORT_CYCLE=0.
- HLT 1111: halted rises on the edge ending T4. All outputs stay 0 for 20 further clocks. Asserting reset gives t_state = 000001 and halted = 0.
- step_mode=1, step=0 for 5 clocks in T2: t_state stays 000010 and pc_inc stays 0. A single step=1 cycle pulses pc_inc once and moves to T3.
- Async reset asserted mid-T5 of LDA, between clock edges: outputs go 0 and t_state = 000001 without waiting for a clock edge.
- Unknown opcode 0111 with SHORT_CYCLE=1: no strobes in T4; next state T1.
